// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: load-size encodings, the MEM/WB bundle and default register count.
package pipe_pkg;

   localparam logic [1:0] LD_BYTE = 2'b00;
   localparam logic [1:0] LD_HALF = 2'b01;
   localparam logic [1:0] LD_WORD = 2'b10;

   localparam int NREGS_DEFAULT = 16;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_to_reg;
      logic [31:0] alu_result;
      logic [31:0] mem_data;
      logic [1:0]  ld_size;
      logic        ld_unsigned;
   } mem_wb_t;

endpackage

// File: rtl/load_extract.sv
// Sub-word load extraction: picks a byte/half/word lane from a little-endian word and extends it.
// Only instantiated when WB_SUBWORD_EN is defined.
module load_extract
   import pipe_pkg::*;
(
   input  logic [31:0] mem_data,
   input  logic [1:0]  off,
   input  logic [1:0]  ld_size,
   input  logic        ld_unsigned,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = mem_data[8*off +: 8];
      half_lane = off[1] ? mem_data[31:16] : mem_data[15:0];
      case (ld_size)
         LD_BYTE: data = {{24{byte_lane[7] & ~ld_unsigned}}, byte_lane};
         LD_HALF: data = {{16{half_lane[15] & ~ld_unsigned}}, half_lane};
         default: data = mem_data;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, result select and register-file write port, retire counter.
// Sub-word load extraction is built only when WB_SUBWORD_EN is defined; otherwise loads return the raw word.
module wb_stage
   import pipe_pkg::*;
#(
   parameter int NREGS = NREGS_DEFAULT,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [4:0]       in_rd,
   input  logic             in_reg_write,
   input  logic             in_mem_to_reg,
   input  logic [31:0]      in_alu_result,
   input  logic [31:0]      in_mem_data,
   input  logic [1:0]       in_ld_size,
   input  logic             in_ld_unsigned,
   input  logic             stall,
   input  logic             flush,
   output logic [4:0]       rd,
   output logic [31:0]      write_data,
   output logic             reg_write,
   output logic [CNT_W-1:0] retired,
   output logic             bad_rd
);

   mem_wb_t          wb;
   mem_wb_t          wb_next;
   logic [31:0]      load_val;
   logic             wr_attempt;
   logic             rd_impl;
   logic             bad_q;
   logic [CNT_W-1:0] cnt;

   always_comb begin
      wb_next            = '0;
      wb_next.valid      = in_valid;
      wb_next.rd         = in_rd;
      wb_next.reg_write  = in_reg_write;
      wb_next.mem_to_reg = in_mem_to_reg;
      wb_next.alu_result = in_alu_result;
      wb_next.mem_data   = in_mem_data;
`ifdef WB_SUBWORD_EN
      wb_next.ld_size     = in_ld_size;
      wb_next.ld_unsigned = in_ld_unsigned;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb <= '0;
      end else if (flush) begin
         wb <= '0;
      end else if (!stall) begin
         wb <= wb_next;
      end
   end

`ifdef WB_SUBWORD_EN
   load_extract u_load_extract (
      .mem_data    (wb.mem_data),
      .off         (wb.alu_result[1:0]),
      .ld_size     (wb.ld_size),
      .ld_unsigned (wb.ld_unsigned),
      .data        (load_val)
   );
`else
   logic unused_ld;
   assign unused_ld = ^{in_ld_size, in_ld_unsigned, wb.ld_size, wb.ld_unsigned};
   assign load_val  = wb.mem_data;
`endif

   assign rd_impl    = 32'(wb.rd) < NREGS;
   assign wr_attempt = wb.valid & wb.reg_write;

   assign rd         = wb.rd;
   assign write_data = wb.mem_to_reg ? load_val : wb.alu_result;
   assign reg_write  = wr_attempt & (wb.rd != 5'd0) & rd_impl;

   // The departing entry has already written, so a flush does not cancel its retirement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         bad_q <= 1'b0;
      end else begin
         if (wb.valid && !stall) cnt <= cnt + CNT_W'(1);
         if (wr_attempt && !rd_impl) bad_q <= 1'b1;
      end
   end

   assign retired = cnt;
   assign bad_rd  = bad_q | (wr_attempt & ~rd_impl);

endmodule
